// File: rtl/img_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : img_pkg
//  Description : Shared definitions for the image scale engine: run-mode
//                encodings, FSM state encoding and destination-size helper.
//  Revision    : 1.0  initial release
// ============================================================================
package img_pkg;

    localparam int DST_W_BITS = 11;
    localparam int DST_H_BITS = 10;

    typedef enum logic [2:0] {
        MODE_COPY = 3'd0,
        MODE_NN2  = 3'd1,
        MODE_NN4  = 3'd2,
        MODE_DEC2 = 3'd3,
        MODE_DEC4 = 3'd4,
        MODE_AVG2 = 3'd5
    } mode_t;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_RUN   = 3'd1,
        ST_AVG   = 3'd2,
        ST_FLUSH = 3'd3,
        ST_DONE  = 3'd4
    } state_t;

    function automatic logic mode_is_legal(input logic [2:0] m);
        return (m <= 3'd5);
    endfunction

    // Destination extent along one axis for a given source extent.
    function automatic logic [DST_W_BITS-1:0] f_dst_dim(input logic [DST_W_BITS-1:0] src,
                                                        input mode_t m);
        case (m)
            MODE_NN2:  return src << 1;
            MODE_NN4:  return src << 2;
            MODE_DEC2: return src >> 1;
            MODE_DEC4: return src >> 2;
            MODE_AVG2: return src >> 1;
            default:   return src;
        endcase
    endfunction

endpackage
`default_nettype wire

// File: rtl/img_scale_engine_if.sv
`default_nettype none
// ============================================================================
//  Module      : img_scale_engine_if
//  Description : Control, ROM-read and RAM-write bundle of the scale engine.
//                master : engine side (drives addresses, write strobe, status)
//                slave  : environment side (drives start/mode and ROM data)
//  Revision    : 1.0  initial release
// ============================================================================
interface img_scale_engine_if
    import img_pkg::*;
#(
    parameter int ADDR_W = 19,
    parameter int PIX_W  = 8
);
    logic                  start;
    logic [2:0]            mode;
    logic [ADDR_W-1:0]     rom_addr;
    logic [PIX_W-1:0]      rom_q;
    logic [ADDR_W-1:0]     ram_addr;
    logic [PIX_W-1:0]      ram_data;
    logic                  ram_we;
    logic [DST_W_BITS-1:0] dst_w;
    logic [DST_H_BITS-1:0] dst_h;
    logic                  busy;
    logic                  done;
    logic                  err;

    modport master (
        input  start, mode, rom_q,
        output rom_addr, ram_addr, ram_data, ram_we, dst_w, dst_h, busy, done, err
    );

    modport slave (
        output start, mode, rom_q,
        input  rom_addr, ram_addr, ram_data, ram_we, dst_w, dst_h, busy, done, err
    );
endinterface
`default_nettype wire

// File: rtl/img_addr_gen.sv
`default_nettype none
// ============================================================================
//  Module      : img_addr_gen
//  Description : Destination raster walker. Keeps dst x/y counters, the
//                2x2 sub-sample phase for averaging, and a source row-base
//                accumulator so the ROM address needs no multiplier.
//  Ports       : i_load      clear counters (accepted start)
//                i_adv       advance by one ROM read
//                i_mode      latched run mode
//                i_dst_w/h   latched destination size
//                o_rom_addr  source read address for the current read
//                o_phase     averaging sub-sample index (x0y0,x1y0,x0y1,x1y1)
//                o_pix_end   current read completes a dst pixel
//                o_last      current read is the final read of the run
//  Revision    : 1.0  initial release
// ============================================================================
module img_addr_gen
    import img_pkg::*;
#(
    parameter int SRC_W  = 160,
    parameter int ADDR_W = 19
)
(
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  i_load,
    input  logic                  i_adv,
    input  mode_t                 i_mode,
    input  logic [DST_W_BITS-1:0] i_dst_w,
    input  logic [DST_H_BITS-1:0] i_dst_h,
    output logic [ADDR_W-1:0]     o_rom_addr,
    output logic [1:0]            o_phase,
    output logic                  o_pix_end,
    output logic                  o_last
);

    localparam logic [ADDR_W-1:0] c_ROW_1 = ADDR_W'(SRC_W);
    localparam logic [ADDR_W-1:0] c_ROW_2 = ADDR_W'(2 * SRC_W);
    localparam logic [ADDR_W-1:0] c_ROW_4 = ADDR_W'(4 * SRC_W);

    logic [DST_W_BITS-1:0] r_x;
    logic [DST_H_BITS-1:0] r_y;
    logic [1:0]            r_phase;
    logic [ADDR_W-1:0]     r_row_base;

    logic [ADDR_W-1:0]     w_x_ext;
    logic [ADDR_W-1:0]     w_src_x;
    logic [ADDR_W-1:0]     w_row_step;
    logic [ADDR_W-1:0]     w_sub_row;
    logic                  w_x_last;
    logic                  w_y_last;
    logic                  w_pix_end;

    assign w_x_ext = ADDR_W'(r_x);

    // Source column per mode, and how far the source row base moves when
    // dst y steps. Nearest-neighbour only moves on the last replicated line.
    always_comb begin
        w_src_x    = w_x_ext;
        w_row_step = c_ROW_1;
        case (i_mode)
            MODE_NN2: begin
                w_src_x    = w_x_ext >> 1;
                w_row_step = r_y[0] ? c_ROW_1 : '0;
            end
            MODE_NN4: begin
                w_src_x    = w_x_ext >> 2;
                w_row_step = (&r_y[1:0]) ? c_ROW_1 : '0;
            end
            MODE_DEC2: begin
                w_src_x    = w_x_ext << 1;
                w_row_step = c_ROW_2;
            end
            MODE_DEC4: begin
                w_src_x    = w_x_ext << 2;
                w_row_step = c_ROW_4;
            end
            MODE_AVG2: begin
                w_src_x    = {w_x_ext[ADDR_W-2:0], r_phase[0]};
                w_row_step = c_ROW_2;
            end
            default: ;
        endcase
    end

    assign w_sub_row  = ((i_mode == MODE_AVG2) && r_phase[1]) ? c_ROW_1 : '0;
    assign o_rom_addr = r_row_base + w_sub_row + w_src_x;

    assign w_x_last   = (r_x == (i_dst_w - 11'd1));
    assign w_y_last   = (r_y == (i_dst_h - 10'd1));
    assign w_pix_end  = (i_mode != MODE_AVG2) || (r_phase == 2'd3);
    assign o_pix_end  = w_pix_end;
    assign o_phase    = r_phase;
    assign o_last     = w_x_last & w_y_last & w_pix_end;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_x        <= '0;
            r_y        <= '0;
            r_phase    <= '0;
            r_row_base <= '0;
        end else if (i_load) begin
            r_x        <= '0;
            r_y        <= '0;
            r_phase    <= '0;
            r_row_base <= '0;
        end else if (i_adv) begin
            if (i_mode == MODE_AVG2) begin
                r_phase <= r_phase + 2'd1;
            end
            if (w_pix_end) begin
                if (!w_x_last) begin
                    r_x <= r_x + 11'd1;
                end else begin
                    r_x <= '0;
                    // Hold y on the final line so idle addresses stay in range.
                    if (!w_y_last) begin
                        r_y        <= r_y + 10'd1;
                        r_row_base <= r_row_base + w_row_step;
                    end
                end
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/img_scale_engine.sv
`default_nettype none
// ============================================================================
//  Module      : img_scale_engine
//  Description : Copies a SRC_W x SRC_H grayscale image from synchronous ROM
//                into frame-buffer RAM, rescaled by run-time mode (copy,
//                NN x2/x4, decimate /2 /4, 2x2 box average /2).
//  Ports       : clk    system clock
//                rst_n  asynchronous active-low reset (deassert synchronously)
//                bus    img_scale_engine_if.master: start/mode in, ROM read
//                       port, RAM write port, dst_w/dst_h, busy/done/err
//  Revision    : 1.0  initial release
// ============================================================================
module img_scale_engine
    import img_pkg::*;
#(
    parameter int SRC_W  = 160,
    parameter int SRC_H  = 120,
    parameter int PIX_W  = 8,
    parameter int ADDR_W = 19
)
(
    input  logic                   clk,
    input  logic                   rst_n,
    img_scale_engine_if.master     bus
);

    localparam logic [DST_W_BITS-1:0] c_SRC_W = DST_W_BITS'(SRC_W);
    localparam logic [DST_W_BITS-1:0] c_SRC_H = DST_W_BITS'(SRC_H);
    localparam logic [PIX_W+1:0]      c_RND   = (PIX_W+2)'(2);

    state_t                r_state;
    state_t                w_next;
    mode_t                 r_mode;
    mode_t                 w_mode_in;

    logic                  w_can_start;
    logic                  w_accept;
    logic                  w_reject;
    logic                  w_busy;
    logic                  w_issue;

    logic [DST_W_BITS-1:0] w_new_w;
    logic [DST_W_BITS-1:0] w_new_h_full;
    logic [DST_W_BITS-1:0] r_dst_w;
    logic [DST_H_BITS-1:0] r_dst_h;

    logic [ADDR_W-1:0]     w_rom_addr;
    logic [1:0]            w_phase;
    logic                  w_pix_end;
    logic                  w_last;

    logic                  r_done;
    logic                  r_err;
    logic                  r_we;
    logic [ADDR_W-1:0]     r_ram_addr;
    logic [ADDR_W-1:0]     r_wr_next;
    logic                  r_rd_valid;
    logic [1:0]            r_rd_phase;
    logic [PIX_W+1:0]      r_acc;
    logic [PIX_W+1:0]      w_sum;

    assign w_mode_in    = mode_t'(bus.mode);
    // A new run may begin from IDLE or from the single DONE cycle.
    assign w_can_start  = (r_state == ST_IDLE) || (r_state == ST_DONE);
    assign w_accept     = w_can_start & bus.start &  mode_is_legal(bus.mode);
    assign w_reject     = w_can_start & bus.start & ~mode_is_legal(bus.mode);
    assign w_new_w      = f_dst_dim(c_SRC_W, w_mode_in);
    assign w_new_h_full = f_dst_dim(c_SRC_H, w_mode_in);

    img_addr_gen #(
        .SRC_W  (SRC_W),
        .ADDR_W (ADDR_W)
    ) u_addr_gen (
        .clk        (clk),
        .rst_n      (rst_n),
        .i_load     (w_accept),
        .i_adv      (w_issue),
        .i_mode     (r_mode),
        .i_dst_w    (r_dst_w),
        .i_dst_h    (r_dst_h),
        .o_rom_addr (w_rom_addr),
        .o_phase    (w_phase),
        .o_pix_end  (w_pix_end),
        .o_last     (w_last)
    );

    // ---------------- FSM: state register ----------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // ---------------- FSM: next state ----------------
    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE, ST_DONE: begin
                if (w_accept) begin
                    w_next = (w_mode_in == MODE_AVG2) ? ST_AVG : ST_RUN;
                end else begin
                    w_next = ST_IDLE;
                end
            end
            ST_RUN, ST_AVG: begin
                if (w_last) begin
                    w_next = ST_FLUSH;
                end
            end
            ST_FLUSH: w_next = ST_DONE;
            default:  w_next = ST_IDLE;
        endcase
    end

    // ---------------- FSM: outputs ----------------
    always_comb begin
        w_busy  = 1'b0;
        w_issue = 1'b0;
        case (r_state)
            ST_RUN, ST_AVG: begin
                w_busy  = 1'b1;
                w_issue = 1'b1;
            end
            ST_FLUSH: w_busy = 1'b1;
            default: ;
        endcase
    end

    // Run control: latched mode/size and status levels.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_mode  <= MODE_COPY;
            r_dst_w <= '0;
            r_dst_h <= '0;
            r_done  <= 1'b0;
            r_err   <= 1'b0;
        end else if (w_accept) begin
            r_mode  <= w_mode_in;
            r_dst_w <= w_new_w;
            r_dst_h <= w_new_h_full[DST_H_BITS-1:0];
            r_done  <= 1'b0;
            r_err   <= 1'b0;
        end else if (w_reject) begin
            r_done  <= 1'b0;
            r_err   <= 1'b1;
        end else if (r_state == ST_FLUSH) begin
            r_done  <= 1'b1;
        end
    end

    // Write strobe and address are delayed one cycle so they line up with
    // the ROM data of the read that completes each dst pixel.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_we       <= 1'b0;
            r_ram_addr <= '0;
            r_wr_next  <= '0;
            r_rd_valid <= 1'b0;
            r_rd_phase <= '0;
        end else begin
            r_we       <= w_issue & w_pix_end;
            r_rd_valid <= w_issue;
            r_rd_phase <= w_phase;
            if (w_accept) begin
                r_wr_next <= '0;
            end else if (w_issue && w_pix_end) begin
                r_ram_addr <= r_wr_next;
                r_wr_next  <= r_wr_next + 1'b1;
            end
        end
    end

    // Box-average accumulator: holds the first three samples; the fourth is
    // added combinationally in the write cycle. 4*max+2 fits PIX_W+2 bits.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_acc <= '0;
        end else if (r_rd_valid) begin
            if (r_rd_phase == 2'd0) begin
                r_acc <= {2'b00, bus.rom_q};
            end else begin
                r_acc <= r_acc + {2'b00, bus.rom_q};
            end
        end
    end

    assign w_sum = r_acc + {2'b00, bus.rom_q} + c_RND;

    assign bus.rom_addr = w_rom_addr;
    assign bus.ram_addr = r_ram_addr;
    assign bus.ram_we   = r_we;
    assign bus.ram_data = !r_we ? '0 :
                          (r_mode == MODE_AVG2) ? w_sum[PIX_W+1:2] : bus.rom_q;
    assign bus.dst_w    = r_dst_w;
    assign bus.dst_h    = r_dst_h;
    assign bus.busy     = w_busy;
    assign bus.done     = r_done;
    assign bus.err      = r_err;

endmodule
`default_nettype wire

// File: tb/tb_img_scale_engine.sv
`default_nettype none
// ============================================================================
//  Module      : tb_img_scale_engine
//  Description : Self-checking bench for img_scale_engine (8x4 source).
//  Revision    : 1.0  initial release
// ============================================================================
module tb_img_scale_engine;

    localparam int SW = 8;
    localparam int SH = 4;
    localparam int PW = 8;
    localparam int AW = 12;
    localparam int NPIX = SW * SH;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    img_scale_engine_if #(.ADDR_W(AW), .PIX_W(PW)) bus ();

    img_scale_engine #(.SRC_W(SW), .SRC_H(SH), .PIX_W(PW), .ADDR_W(AW)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    logic [7:0] rom [0:NPIX-1];

    always @(posedge clk) begin
        if (bus.rom_addr < AW'(NPIX)) bus.rom_q <= rom[bus.rom_addr[4:0]];
        else                          bus.rom_q <= 8'h00;
    end

    int         wr_cnt  = 0;
    int         oob_cnt = 0;
    logic [AW-1:0] cap_addr [0:1023];
    logic [7:0]    cap_data [0:1023];

    always @(negedge clk) begin
        if (rst_n) begin
            if (bus.ram_we) begin
                if (wr_cnt < 1024) begin
                    cap_addr[wr_cnt] = bus.ram_addr;
                    cap_data[wr_cnt] = bus.ram_data;
                end
                wr_cnt++;
            end
            if (bus.rom_addr >= AW'(NPIX)) oob_cnt++;
        end
    end

    int checks   = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d required %0d", name, act, exp);
        end
    endtask

    task automatic fill_rom(input bit rnd);
        for (int i = 0; i < NPIX; i++) rom[i] = rnd ? 8'($urandom_range(0, 255)) : 8'(i);
    endtask

    // Reference: scaled image defined directly from source coordinates.
    function automatic int model_pix(input int m, input int x, input int y);
        int sum;
        case (m)
            0: return int'(rom[y*SW + x]);
            1: return int'(rom[(y/2)*SW + x/2]);
            2: return int'(rom[(y/4)*SW + x/4]);
            3: return int'(rom[(y*2)*SW + x*2]);
            4: return int'(rom[(y*4)*SW + x*4]);
            default: begin
                sum = int'(rom[(2*y)*SW + 2*x]) + int'(rom[(2*y)*SW + 2*x + 1])
                    + int'(rom[(2*y+1)*SW + 2*x]) + int'(rom[(2*y+1)*SW + 2*x + 1]);
                return (sum + 2) / 4;
            end
        endcase
    endfunction

    function automatic int model_w(input int m);
        case (m)
            0: return SW;
            1: return SW * 2;
            2: return SW * 4;
            4: return SW / 4;
            default: return SW / 2;
        endcase
    endfunction

    function automatic int model_h(input int m);
        case (m)
            0: return SH;
            1: return SH * 2;
            2: return SH * 4;
            4: return SH / 4;
            default: return SH / 2;
        endcase
    endfunction

    // Leaves the caller at the falling edge after the accepting clock edge.
    task automatic start_run(input int m);
        @(negedge clk);
        bus.mode  = 3'(m);
        bus.start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus.start = 1'b0;
    endtask

    task automatic run_check(input string tag, input int m, input int ew, input int eh);
        int cyc;
        int p;
        int bad;
        int ex;
        wr_cnt  = 0;
        oob_cnt = 0;
        start_run(m);
        if (m > 5) begin
            chk({tag, " err"}, 64'(bus.err), 1);
            chk({tag, " done"}, 64'(bus.done), 0);
            chk({tag, " busy"}, 64'(bus.busy), 0);
            repeat (4) @(negedge clk);
            chk({tag, " writes"}, 64'(wr_cnt), 0);
            return;
        end
        chk({tag, " start_state"}, 64'({bus.busy, bus.done, bus.err}), 64'(3'b100));
        cyc = 1;
        while (!bus.done && cyc < 3000) begin
            @(negedge clk);
            cyc++;
        end
        p = ew * eh;
        chk({tag, " cycles"}, 64'(cyc), 64'(((m == 5) ? 4 * p : p) + 2));
        chk({tag, " dst_w"}, 64'(bus.dst_w), 64'(ew));
        chk({tag, " dst_h"}, 64'(bus.dst_h), 64'(eh));
        chk({tag, " busy_end"}, 64'(bus.busy), 0);
        chk({tag, " writes"}, 64'(wr_cnt), 64'(p));
        chk({tag, " rom_range"}, 64'(oob_cnt), 0);
        bad = 0;
        for (int i = 0; i < p && i < 1024; i++) begin
            ex = model_pix(m, i % ew, i / ew);
            if (cap_addr[i] !== AW'(i) || cap_data[i] !== 8'(ex)) begin
                if (bad == 0)
                    $display("  %s first bad write %0d: addr %0d data %0d, want addr %0d data %0d",
                             tag, i, cap_addr[i], cap_data[i], i, ex);
                bad++;
            end
        end
        chk({tag, " pixels"}, 64'(bad), 0);
    endtask

    typedef struct {
        int mode;
        bit rnd;
        int ew;
        int eh;
    } vec_t;

    vec_t vt [0:9];

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        int cyc;
        int snap;
        int m;

        bus.start = 1'b0;
        bus.mode  = 3'd0;
        fill_rom(0);

        vt[0] = '{0, 1'b0,  8,  4};
        vt[1] = '{1, 1'b0, 16,  8};
        vt[2] = '{2, 1'b0, 32, 16};
        vt[3] = '{3, 1'b0,  4,  2};
        vt[4] = '{4, 1'b0,  2,  1};
        vt[5] = '{5, 1'b0,  4,  2};
        vt[6] = '{5, 1'b1,  4,  2};
        vt[7] = '{6, 1'b0,  0,  0};
        vt[8] = '{7, 1'b0,  0,  0};
        vt[9] = '{0, 1'b1,  8,  4};

        repeat (3) @(negedge clk);
        chk("reset outputs", 64'({bus.ram_we, bus.ram_addr, bus.ram_data, bus.rom_addr,
                                  bus.dst_w, bus.dst_h, bus.busy, bus.done, bus.err}), 0);
        rst_n = 1'b1;

        for (int i = 0; i < 10; i++) begin
            fill_rom(vt[i].rnd);
            run_check($sformatf("vec%0d", i), vt[i].mode, vt[i].ew, vt[i].eh);
        end

        // NN x2 replication points
        fill_rom(0);
        run_check("nn2", 1, 16, 8);
        chk("nn2 addr16", 64'(cap_data[16]), 0);
        chk("nn2 addr17", 64'(cap_data[17]), 0);
        chk("nn2 addr18", 64'(cap_data[18]), 1);
        chk("nn2 addr32", 64'(cap_data[32]), 8);

        // Decimate /4 gives two pixels
        run_check("dec4", 4, 2, 1);
        chk("dec4 pix0", 64'(cap_data[0]), 0);
        chk("dec4 pix1", 64'(cap_data[1]), 4);

        // Box average rounding and saturation-free full scale
        fill_rom(0);
        rom[0] = 8'd10;  rom[1] = 8'd11;  rom[8] = 8'd12;  rom[9] = 8'd13;
        rom[2] = 8'd255; rom[3] = 8'd255; rom[10] = 8'd255; rom[11] = 8'd255;
        run_check("avg", 5, 4, 2);
        chk("avg pix0", 64'(cap_data[0]), 12);
        chk("avg pix1", 64'(cap_data[1]), 255);

        // Start pulse during a run is ignored
        fill_rom(0);
        wr_cnt = 0;
        start_run(0);
        repeat (5) @(negedge clk);
        bus.mode  = 3'd1;
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        bus.mode  = 3'd0;
        cyc = 7;
        while (!bus.done && cyc < 3000) begin
            @(negedge clk);
            cyc++;
        end
        chk("busy_start cycles", 64'(cyc), 34);
        chk("busy_start writes", 64'(wr_cnt), 32);
        chk("busy_start dst", 64'({bus.dst_w, bus.dst_h}), 64'({11'd8, 10'd4}));

        // Reset in the middle of a copy run
        wr_cnt = 0;
        start_run(0);
        n = 0;
        while (!(bus.ram_we && bus.ram_addr == AW'(10)) && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk("midreset reached write10", 64'(n < 100), 1);
        #1 rst_n = 1'b0;
        #1;
        chk("midreset outputs", 64'({bus.ram_we, bus.busy, bus.done, bus.ram_addr, bus.dst_w}), 0);
        snap = wr_cnt;
        @(negedge clk);
        rst_n = 1'b1;
        repeat (4) @(negedge clk);
        chk("midreset no writes", 64'(wr_cnt), 64'(snap));
        chk("midreset idle", 64'({bus.busy, bus.done}), 0);
        run_check("after_reset", 0, 8, 4);

        // Randomised runs against the reference model
        for (int r = 0; r < 8; r++) begin
            m = $urandom_range(0, 7);
            fill_rom(1);
            run_check($sformatf("rand%0d_m%0d", r, m), m,
                      (m > 5) ? 0 : model_w(m), (m > 5) ? 0 : model_h(m));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
